// File: rtl/clk_rate_monitor_if.sv
// Bundles the measured clock, enable and the measurement results of clk_rate_monitor.
// The monitor uses the slave modport and the stimulus or consumer side uses the master modport.
interface clk_rate_monitor_if #(
  parameter int CNT_W = 16
) ();
  logic             div_clk;
  logic             enable;
  logic [CNT_W-1:0] edge_count;
  logic             meas_valid;
  logic             in_range;
  logic             stuck;

  modport master (
    output div_clk, enable,
    input  edge_count, meas_valid, in_range, stuck
  );

  modport slave (
    input  div_clk, enable,
    output edge_count, meas_valid, in_range, stuck
  );
endinterface

// File: rtl/clk_rate_monitor.sv
// Counts synchronized div_clk rising edges over back-to-back windows of clk_in cycles.
// Reports the count, a tolerance check against the expected rate, and a stuck-clock flag.
//
//   state   | meaning
//   IDLE    | not measuring; counters held at zero, stuck cleared
//   MEASURE | window running; edges and stuck time being counted
module clk_rate_monitor #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int EXPECT_EDGES  = 64,
  parameter int TOL_EDGES     = 1,
  parameter int STUCK_CYCLES  = 64,
  parameter int CNT_W         = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  clk_rate_monitor_if.slave mon
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);
  localparam int LO_INT = (EXPECT_EDGES > TOL_EDGES) ? (EXPECT_EDGES - TOL_EDGES) : 0;
  localparam int HI_INT = EXPECT_EDGES + TOL_EDGES;

  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_MAX   = STK_W'(STUCK_CYCLES);
  localparam logic [CNT_W:0]   LO_EXT    = (CNT_W + 1)'(LO_INT);
  localparam logic [CNT_W:0]   HI_EXT    = (CNT_W + 1)'(HI_INT);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [STK_W-1:0] stuck_cnt_q;
  logic [CNT_W-1:0] edge_count_q;
  logic             meas_valid_q;
  logic             in_range_q;
  logic             stuck_q;

  logic             rise;
  logic             measuring;
  logic [CNT_W:0]   sum_ext;
  logic [CNT_W-1:0] edge_sum_d;
  logic             in_range_d;
  logic [STK_W-1:0] stuck_cnt_d;

  assign rise      = s2_q & ~s3_q;
  assign measuring = (state_q == MEASURE) && mon.enable;

  // Saturating count including a rise on the current cycle, so a rise on the final
  // window cycle closes into this window rather than leaking into the next one.
  always_comb begin
    sum_ext    = {1'b0, edge_cnt_q} + (CNT_W + 1)'(rise);
    edge_sum_d = sum_ext[CNT_W] ? {CNT_W{1'b1}} : sum_ext[CNT_W-1:0];
    in_range_d = ({1'b0, edge_sum_d} >= LO_EXT) && ({1'b0, edge_sum_d} <= HI_EXT);
  end

  always_comb begin
    stuck_cnt_d = '0;
    if (measuring && !rise) begin
      stuck_cnt_d = (stuck_cnt_q == STK_MAX) ? stuck_cnt_q : stuck_cnt_q + STK_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      stuck_cnt_q  <= '0;
      edge_count_q <= '0;
      meas_valid_q <= 1'b0;
      in_range_q   <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      s1_q         <= mon.div_clk;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      meas_valid_q <= 1'b0;
      stuck_cnt_q  <= stuck_cnt_d;
      stuck_q      <= (stuck_cnt_d == STK_MAX);
      case (state_q)
        IDLE: begin
          win_cnt_q  <= '0;
          edge_cnt_q <= '0;
          if (mon.enable) state_q <= MEASURE;
        end
        MEASURE: begin
          // A falling enable wins over a coinciding window end: nothing is published.
          if (!mon.enable) begin
            state_q    <= IDLE;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
          end else if (win_cnt_q == WIN_LAST) begin
            edge_count_q <= edge_sum_d;
            in_range_q   <= in_range_d;
            meas_valid_q <= 1'b1;
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
          end else begin
            win_cnt_q  <= win_cnt_q + WIN_W'(1);
            edge_cnt_q <= edge_sum_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mon.edge_count = edge_count_q;
  assign mon.meas_valid = meas_valid_q;
  assign mon.in_range   = in_range_q;
  assign mon.stuck      = stuck_q;

endmodule

// File: tb/tb_clk_rate_monitor.sv
// Directed bench for clk_rate_monitor: div_clk is generated 2 ns after clk_in edges with
// programmable high/low times and an optional limit on the number of rising edges.
module tb_clk_rate_monitor;
  logic clk_in;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  int   div_hi;
  int   div_lo;
  int   div_limit;
  logic div_run;

  clk_rate_monitor_if #(.CNT_W(16)) mon_if ();

  clk_rate_monitor #(
    .WINDOW_CYCLES(1024), .EXPECT_EDGES(64), .TOL_EDGES(1), .STUCK_CYCLES(64), .CNT_W(16)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .mon   (mon_if)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Rising edge of div_clk on phase 0 of each period, at most div_limit edges (-1 = unlimited).
  initial begin
    int ph;
    int emitted;
    ph = 0;
    emitted = 0;
    mon_if.div_clk = 1'b0;
    forever begin
      @(posedge clk_in);
      #2;
      if (!div_run) begin
        mon_if.div_clk = 1'b0;
        ph = 0;
        emitted = 0;
      end else begin
        if (ph == 0) begin
          if (div_limit < 0 || emitted < div_limit) begin
            mon_if.div_clk = 1'b1;
            emitted++;
          end
        end else if (ph == div_hi) begin
          mon_if.div_clk = 1'b0;
        end
        ph = (ph + 1 >= div_hi + div_lo) ? 0 : ph + 1;
      end
    end
  end

  // Returns the number of falling clk_in edges until meas_valid is seen, or -1 on timeout.
  task automatic wait_valid(input int max_cyc, output int k);
    k = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk_in);
      if (mon_if.meas_valid === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic go_idle();
    mon_if.enable = 1'b0;
    div_run = 1'b0;
    div_limit = -1;
    repeat (6) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mon_if.enable = 1'b0;
    repeat (3) @(negedge clk_in);
    n_cmp++; if (mon_if.edge_count !== 16'd0) begin n_err++; $display("FAIL reset_edge_count: got %0d expected 0", mon_if.edge_count); end
    n_cmp++; if (mon_if.meas_valid !== 1'b0) begin n_err++; $display("FAIL reset_meas_valid: got %b expected 0", mon_if.meas_valid); end
    n_cmp++; if (mon_if.in_range !== 1'b0) begin n_err++; $display("FAIL reset_in_range: got %b expected 0", mon_if.in_range); end
    n_cmp++; if (mon_if.stuck !== 1'b0) begin n_err++; $display("FAIL reset_stuck: got %b expected 0", mon_if.stuck); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_nominal();
    int k;
    div_hi = 8; div_lo = 8; div_limit = -1;
    mon_if.enable = 1'b1;
    div_run = 1'b1;
    wait_valid(1100, k);
    n_cmp++; if (k !== 1025) begin n_err++; $display("FAIL nom_first_valid_cycle: got %0d expected 1025", k); end
    n_cmp++; if (mon_if.edge_count !== 16'd64) begin n_err++; $display("FAIL nom_count1: got %0d expected 64", mon_if.edge_count); end
    n_cmp++; if (mon_if.in_range !== 1'b1) begin n_err++; $display("FAIL nom_in_range: got %b expected 1", mon_if.in_range); end
    n_cmp++; if (mon_if.stuck !== 1'b0) begin n_err++; $display("FAIL nom_stuck: got %b expected 0", mon_if.stuck); end
    @(negedge clk_in);
    n_cmp++; if (mon_if.meas_valid !== 1'b0) begin n_err++; $display("FAIL nom_pulse_width: got %b expected 0", mon_if.meas_valid); end
    wait_valid(1100, k);
    n_cmp++; if (k !== 1023) begin n_err++; $display("FAIL nom_second_valid_cycle: got %0d expected 1023", k); end
    n_cmp++; if (mon_if.edge_count !== 16'd64) begin n_err++; $display("FAIL nom_count2: got %0d expected 64", mon_if.edge_count); end
  endtask

  task automatic test_enable_drop();
    int k;
    repeat (500) @(negedge clk_in);
    mon_if.enable = 1'b0;
    wait_valid(1200, k);
    n_cmp++; if (k !== -1) begin n_err++; $display("FAIL drop_no_valid: got %0d expected -1", k); end
    n_cmp++; if (mon_if.edge_count !== 16'd64) begin n_err++; $display("FAIL drop_count_held: got %0d expected 64", mon_if.edge_count); end
    n_cmp++; if (mon_if.in_range !== 1'b1) begin n_err++; $display("FAIL drop_range_held: got %b expected 1", mon_if.in_range); end
    mon_if.enable = 1'b1;
    wait_valid(1100, k);
    n_cmp++; if (k !== 1025) begin n_err++; $display("FAIL drop_reenable_cycle: got %0d expected 1025", k); end
    n_cmp++; if (mon_if.edge_count !== 16'd64) begin n_err++; $display("FAIL drop_reenable_count: got %0d expected 64", mon_if.edge_count); end
  endtask

  task automatic test_simul_drop();
    int k;
    div_hi = 7; div_lo = 7;
    repeat (1023) @(negedge clk_in);
    mon_if.enable = 1'b0;
    wait_valid(8, k);
    n_cmp++; if (k !== -1) begin n_err++; $display("FAIL simul_no_valid: got %0d expected -1", k); end
    n_cmp++; if (mon_if.edge_count !== 16'd64) begin n_err++; $display("FAIL simul_count_held: got %0d expected 64", mon_if.edge_count); end
  endtask

  task automatic test_rates();
    int k;
    go_idle();
    div_hi = 7; div_lo = 7;
    mon_if.enable = 1'b1;
    div_run = 1'b1;
    wait_valid(1100, k);
    n_cmp++; if (k !== 1025) begin n_err++; $display("FAIL p14_valid_cycle: got %0d expected 1025", k); end
    n_cmp++; if (!(mon_if.edge_count == 16'd73 || mon_if.edge_count == 16'd74)) begin n_err++; $display("FAIL p14_count: got %0d expected 73..74", mon_if.edge_count); end
    n_cmp++; if (mon_if.in_range !== 1'b0) begin n_err++; $display("FAIL p14_in_range: got %b expected 0", mon_if.in_range); end
    go_idle();
    div_hi = 7; div_lo = 8;
    mon_if.enable = 1'b1;
    div_run = 1'b1;
    wait_valid(1100, k);
    n_cmp++; if (!(mon_if.edge_count == 16'd68 || mon_if.edge_count == 16'd69)) begin n_err++; $display("FAIL p15_count: got %0d expected 68..69", mon_if.edge_count); end
    n_cmp++; if (mon_if.in_range !== 1'b0) begin n_err++; $display("FAIL p15_in_range: got %b expected 0", mon_if.in_range); end
  endtask

  task automatic test_tolerance();
    int   k;
    int   cnt_tab[4];
    logic rng_tab[4];
    cnt_tab = '{63, 65, 66, 62};
    rng_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 4; t++) begin
      go_idle();
      div_hi = 4; div_lo = 4; div_limit = cnt_tab[t];
      mon_if.enable = 1'b1;
      div_run = 1'b1;
      wait_valid(1100, k);
      n_cmp++; if (mon_if.edge_count !== 16'(cnt_tab[t])) begin n_err++; $display("FAIL tol_count[%0d]: got %0d expected %0d", t, mon_if.edge_count, cnt_tab[t]); end
      n_cmp++; if (mon_if.in_range !== rng_tab[t]) begin n_err++; $display("FAIL tol_in_range[%0d]: got %b expected %b", t, mon_if.in_range, rng_tab[t]); end
    end
    n_cmp++; if (mon_if.stuck !== 1'b1) begin n_err++; $display("FAIL tol_stuck_after_burst: got %b expected 1", mon_if.stuck); end
  endtask

  task automatic test_stuck();
    int k;
    go_idle();
    mon_if.enable = 1'b1;
    repeat (64) @(negedge clk_in);
    n_cmp++; if (mon_if.stuck !== 1'b0) begin n_err++; $display("FAIL stuck_early: got %b expected 0", mon_if.stuck); end
    @(negedge clk_in);
    n_cmp++; if (mon_if.stuck !== 1'b1) begin n_err++; $display("FAIL stuck_assert: got %b expected 1", mon_if.stuck); end
    wait_valid(1100, k);
    n_cmp++; if (k !== 960) begin n_err++; $display("FAIL stuck_valid_cycle: got %0d expected 960", k); end
    n_cmp++; if (mon_if.edge_count !== 16'd0) begin n_err++; $display("FAIL stuck_count: got %0d expected 0", mon_if.edge_count); end
    n_cmp++; if (mon_if.in_range !== 1'b0) begin n_err++; $display("FAIL stuck_in_range: got %b expected 0", mon_if.in_range); end
    div_hi = 8; div_lo = 8;
    div_run = 1'b1;
    repeat (3) @(negedge clk_in);
    n_cmp++; if (mon_if.stuck !== 1'b1) begin n_err++; $display("FAIL stuck_before_clear: got %b expected 1", mon_if.stuck); end
    @(negedge clk_in);
    n_cmp++; if (mon_if.stuck !== 1'b0) begin n_err++; $display("FAIL stuck_cleared: got %b expected 0", mon_if.stuck); end
    div_run = 1'b0;
    repeat (80) @(negedge clk_in);
    n_cmp++; if (mon_if.stuck !== 1'b1) begin n_err++; $display("FAIL stuck_reassert: got %b expected 1", mon_if.stuck); end
    mon_if.enable = 1'b0;
    @(negedge clk_in);
    n_cmp++; if (mon_if.stuck !== 1'b0) begin n_err++; $display("FAIL stuck_idle_clear: got %b expected 0", mon_if.stuck); end
  endtask

  task automatic test_window_boundary();
    int k;
    int off_tab[2];
    int w1_tab[2];
    int w2_tab[2];
    off_tab = '{1021, 1022};
    w1_tab  = '{1, 0};
    w2_tab  = '{0, 1};
    for (int t = 0; t < 2; t++) begin
      go_idle();
      div_hi = 8; div_lo = 8; div_limit = 1;
      mon_if.enable = 1'b1;
      repeat (off_tab[t]) @(negedge clk_in);
      div_run = 1'b1;
      wait_valid(1100, k);
      n_cmp++; if (k !== 1025 - off_tab[t]) begin n_err++; $display("FAIL edge_valid_cycle[%0d]: got %0d expected %0d", t, k, 1025 - off_tab[t]); end
      n_cmp++; if (mon_if.edge_count !== 16'(w1_tab[t])) begin n_err++; $display("FAIL edge_win1[%0d]: got %0d expected %0d", t, mon_if.edge_count, w1_tab[t]); end
      wait_valid(1100, k);
      n_cmp++; if (mon_if.edge_count !== 16'(w2_tab[t])) begin n_err++; $display("FAIL edge_win2[%0d]: got %0d expected %0d", t, mon_if.edge_count, w2_tab[t]); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    go_idle();
    div_hi = 8; div_lo = 8; div_limit = -1;
    mon_if.enable = 1'b1;
    div_run = 1'b1;
    wait_valid(1100, k);
    n_cmp++; if (mon_if.edge_count !== 16'd64) begin n_err++; $display("FAIL rstmid_pre_count: got %0d expected 64", mon_if.edge_count); end
    repeat (300) @(negedge clk_in);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (mon_if.edge_count !== 16'd0) begin n_err++; $display("FAIL rstmid_count: got %0d expected 0", mon_if.edge_count); end
    n_cmp++; if (mon_if.in_range !== 1'b0) begin n_err++; $display("FAIL rstmid_in_range: got %b expected 0", mon_if.in_range); end
    n_cmp++; if (mon_if.meas_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_meas_valid: got %b expected 0", mon_if.meas_valid); end
    @(negedge clk_in);
    rst_n = 1'b1;
    wait_valid(1100, k);
    n_cmp++; if (k !== 1025) begin n_err++; $display("FAIL rstmid_restart_cycle: got %0d expected 1025", k); end
    n_cmp++; if (mon_if.edge_count !== 16'd64) begin n_err++; $display("FAIL rstmid_restart_count: got %0d expected 64", mon_if.edge_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    div_hi = 8;
    div_lo = 8;
    div_limit = -1;
    div_run = 1'b0;
    mon_if.enable = 1'b0;
    test_reset();
    test_nominal();
    test_enable_drop();
    test_simul_drop();
    test_rates();
    test_tolerance();
    test_stuck();
    test_window_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_rate_monitor.md
Name: clk_rate_monitor

Overview:
Checks a divided clock that the rest of the design consumes, from the consuming side, using the 100 MHz system clock. Over fixed windows of system clock cycles it counts rising edges of the divided clock. It reports the count and whether it falls within a tolerance of the expected value. It also flags a divided clock that has stopped toggling. Used as a bring-up and health monitor for divided clocks driving display and timing logic.

Parameters:
WINDOW_CYCLES, 1024, measurement window length in clk_in cycles (>= 2)
EXPECT_EDGES, 64, expected rising edges per window (16-cycle divided period)
TOL_EDGES, 1, allowed +/- deviation from EXPECT_EDGES
STUCK_CYCLES, 64, clk_in cycles without a div_clk rising edge before stuck asserts
CNT_W, 16, width of edge_count

Ports:
clk_in  input  1  100 MHz system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
div_clk  input  1  divided clock under test; treated as asynchronous to clk_in
enable  input  1  1 = measure; 0 = idle, partial window discarded
edge_count  output  CNT_W  rising edges counted in last completed window
meas_valid  output  1  one-cycle pulse when edge_count/in_range update
in_range  output  1  last completed count within EXPECT_EDGES +/- TOL_EDGES
stuck  output  1  no div_clk rising edge for >= STUCK_CYCLES cycles while measuring

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, synchronizer flops 0, counters 0, FSM IDLE. Release is sampled on the next clk_in edge.
- Synchronizer: 2-flop sync (s1, s2), then delay flop s3. rise = s2 & ~s3.
  - A div_clk rising edge produces rise 2-3 clk_in cycles later. rise is exactly 1 cycle wide.
- FSM states: IDLE, MEASURE.
  - IDLE: win_cnt=0, edge_cnt=0, stuck_cnt=0, stuck=0. enable=1 -> MEASURE on the next cycle.
  - MEASURE: win_cnt increments every cycle. edge_cnt increments on rise, saturating at 2^CNT_W-1.
  - MEASURE: enable=0 -> IDLE next cycle. Partial window discarded, no meas_valid. edge_count and in_range hold their last values.
- Window end (MEASURE and win_cnt==WINDOW_CYCLES-1):
  - edge_count <= edge_cnt + rise, saturating. A rise on the final cycle belongs to this window.
  - meas_valid <= 1 for exactly one cycle.
  - in_range <= (count >= max(EXPECT_EDGES-TOL_EDGES, 0)) && (count <= EXPECT_EDGES+TOL_EDGES). Compare in CNT_W+1 bits.
  - win_cnt <= 0 and edge_cnt <= 0 in the same cycle. Windows run back-to-back with no gap.
- First meas_valid: WINDOW_CYCLES cycles after entering MEASURE. Subsequent pulses every WINDOW_CYCLES cycles.
- Stuck detection (MEASURE only):
  - stuck_cnt increments each cycle with no rise and saturates at STUCK_CYCLES. It clears to 0 on rise.
  - stuck = 1 while stuck_cnt == STUCK_CYCLES.
  - stuck clears the cycle after a rise, and in IDLE.
- Simultaneous enable fall and window end: enable has priority. Go to IDLE with no meas_valid and no output update.
- win_cnt width = clog2(WINDOW_CYCLES). stuck_cnt width = clog2(STUCK_CYCLES+1).
- div_clk glitches shorter than one clk_in period may be missed. This is accepted and not required to be counted.

Test Plan:
- Defaults, div_clk period 16 clk_in cycles (8 high/8 low), enable=1 -> meas_valid every 1024 cycles, edge_count=64, in_range=1, stuck=0.
- div_clk period 14 cycles -> edge_count 73 or 74 depending on phase, in_range=0. Period 15 -> 68 or 69, in_range=0.
- div_clk held 0 after enable -> stuck=1 from 64 cycles into MEASURE. First window gives edge_count=0, in_range=0. Resuming toggling clears stuck within 4 cycles of a div_clk rising edge.
- After one good window, drop enable at window cycle 500 -> no meas_valid, edge_count stays 64. Re-enable -> next meas_valid exactly 1024 cycles after MEASURE entry.
- Align a div_clk rise so rise lands on win_cnt==1023 -> that edge is counted in the closing window, not the next one.
- Pulse rst_n low mid-window, between clk_in edges -> all outputs 0 immediately, no meas_valid. After release with enable=1, measurement restarts from win_cnt=0.
